// File: rtl/pluck_envelope.sv
// pluck_envelope: gates the speaker square wave with a PWM duty that follows a pluck attack/decay envelope
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tone_in   square wave from the note/song mux
//   strike    one-cycle pulse that starts or retriggers the envelope
//   hold      freezes the envelope while decaying (sustain)
//   out       registered gated PWM audio
//   amplitude registered envelope value
//   busy      envelope active (not idle)
module pluck_envelope #(
    parameter int PWM_BITS    = 8,
    parameter int ATTACK_TICK = 1953,
    parameter int DECAY_TICK  = 195312
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tone_in,
    input  logic                strike,
    input  logic                hold,
    output logic                out,
    output logic [PWM_BITS-1:0] amplitude,
    output logic                busy
);
    localparam logic [PWM_BITS-1:0] AMAX    = '1;
    localparam logic [PWM_BITS-1:0] ONE     = PWM_BITS'(1);
    localparam logic [31:0]         ATK_LIM = 32'(ATTACK_TICK - 1);
    localparam logic [31:0]         DEC_LIM = 32'(DECAY_TICK - 1);
    typedef enum logic [1:0] {IDLE, ATTACK, DECAY} state_t;
    state_t              state, state_nx;
    logic [31:0]         tick_cnt, tick_nx;
    logic [PWM_BITS-1:0] amp_nx, pwm_cnt;
    logic                tone_r, run, tick;
    assign run  = state == ATTACK || (state == DECAY && !hold);
    assign tick = run && tick_cnt == (state == ATTACK ? ATK_LIM : DEC_LIM);
    assign busy = state != IDLE;
    // strike wins over a coincident tick and keeps the amplitude, so a retrigger never clicks
    always_comb begin
        state_nx = state;
        amp_nx   = amplitude;
        tick_nx  = run ? tick_cnt + 32'd1 : tick_cnt;
        if (strike) begin
            state_nx = ATTACK;
            tick_nx  = '0;
        end else if (state == IDLE) begin
            amp_nx = '0;
        end else if (tick) begin
            tick_nx = '0;
            if (state == ATTACK) begin
                if (amplitude < AMAX) amp_nx = amplitude + ONE;
                else state_nx = DECAY;
            end else if (amplitude <= ONE) begin
                amp_nx   = '0;
                state_nx = IDLE;
            end else begin
                amp_nx = amplitude - ONE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            amplitude <= '0;
            pwm_cnt   <= '0;
            tone_r    <= 1'b0;
            out       <= 1'b0;
        end else begin
            state     <= state_nx;
            tick_cnt  <= tick_nx;
            amplitude <= amp_nx;
            pwm_cnt   <= pwm_cnt + ONE;
            tone_r    <= tone_in;
            out       <= tone_r & (pwm_cnt < amplitude);
        end
    end
endmodule

// File: tb/tb_pluck_envelope.sv
// tb_pluck_envelope: directed scoreboard bench for pluck_envelope with PWM_BITS=4, ATTACK_TICK=4, DECAY_TICK=8
module tb_pluck_envelope;
    logic       clk = 1'b0;
    logic       rst_n, tone_in, strike, hold, out, busy;
    logic [3:0] amplitude;
    logic [3:0] pwm_m;
    int         vectors = 0;
    int         miscompares = 0;
    int         hi_cnt;
    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];
    pluck_envelope #(.PWM_BITS(4), .ATTACK_TICK(4), .DECAY_TICK(8)) dut (
        .clk(clk), .rst_n(rst_n), .tone_in(tone_in), .strike(strike),
        .hold(hold), .out(out), .amplitude(amplitude), .busy(busy)
    );
    always #5 clk = ~clk;
    // reference PWM phase: free-running, cleared by reset
    always @(posedge clk or negedge rst_n)
        if (!rst_n) pwm_m <= 4'd0;
        else pwm_m <= pwm_m + 4'd1;
    function automatic void push(input string t, input logic [7:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endfunction
    task automatic cmp(input logic [7:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0d required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask
    task automatic chk(input string t, input logic [7:0] obs, input logic [7:0] v);
        push(t, v);
        cmp(obs);
    endtask
    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic strike_pulse();
        strike = 1'b1;
        clocks(1);
        strike = 1'b0;
    endtask
    task automatic wait_amp(input logic [3:0] v);
        int n = 0;
        while (amplitude !== v && n < 400) begin
            clocks(1);
            n++;
        end
        chk("wait_amp", {4'd0, amplitude}, {4'd0, v});
    endtask
    task automatic duty_count();
        hi_cnt = 0;
        repeat (16) begin
            clocks(1);
            hi_cnt += int'(out);
        end
    endtask
    initial begin
        logic [3:0] p;
        rst_n = 1'b0; strike = 1'b0; hold = 1'b0; tone_in = 1'b0;
        #2;
        chk("rst_amp", {4'd0, amplitude}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_out", {7'd0, out}, 8'd0);
        #20 rst_n = 1'b1;
        clocks(1);
        // asynchronous reset in the middle of an attack
        strike_pulse();
        clocks(4);
        chk("pre_rst_amp", {4'd0, amplitude}, 8'd1);
        chk("pre_rst_busy", {7'd0, busy}, 8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_amp", {4'd0, amplitude}, 8'd0);
        chk("async_busy", {7'd0, busy}, 8'd0);
        chk("async_out", {7'd0, out}, 8'd0);
        #2 rst_n = 1'b1;
        clocks(1);
        for (int i = 0; i < 20; i++) begin
            tone_in = ~tone_in;
            clocks(1);
            chk("idle_out", {7'd0, out}, 8'd0);
        end
        // full envelope, strike sampled at edge 0
        tone_in = 1'b1;
        strike_pulse();
        chk("env_busy_e0", {7'd0, busy}, 8'd1);
        clocks(3);
        chk("env_amp_e3", {4'd0, amplitude}, 8'd0);
        clocks(1);
        chk("env_amp_e4", {4'd0, amplitude}, 8'd1);
        clocks(56);
        chk("env_amp_e60", {4'd0, amplitude}, 8'd15);
        clocks(11);
        chk("env_amp_e71", {4'd0, amplitude}, 8'd15);
        clocks(1);
        chk("env_amp_e72", {4'd0, amplitude}, 8'd14);
        clocks(111);
        chk("env_amp_e183", {4'd0, amplitude}, 8'd1);
        chk("env_busy_e183", {7'd0, busy}, 8'd1);
        clocks(1);
        chk("env_amp_e184", {4'd0, amplitude}, 8'd0);
        chk("env_busy_e184", {7'd0, busy}, 8'd0);
        clocks(1);
        chk("env_out_idle", {7'd0, out}, 8'd0);
        // hold at full scale: duty and frozen tick count
        strike_pulse();
        clocks(67);
        chk("hold_amp_e67", {4'd0, amplitude}, 8'd15);
        hold = 1'b1;
        duty_count();
        chk("duty15_count", 8'(hi_cnt), 8'd15);
        chk("duty15_amp", {4'd0, amplitude}, 8'd15);
        hold = 1'b0;
        clocks(4);
        chk("resume_amp_r4", {4'd0, amplitude}, 8'd15);
        clocks(1);
        chk("resume_amp_r5", {4'd0, amplitude}, 8'd14);
        // retrigger mid-decay at amplitude 6
        wait_amp(4'd6);
        strike_pulse();
        chk("retrig_amp_s0", {4'd0, amplitude}, 8'd6);
        chk("retrig_busy_s0", {7'd0, busy}, 8'd1);
        clocks(3);
        chk("retrig_amp_s3", {4'd0, amplitude}, 8'd6);
        clocks(1);
        chk("retrig_amp_s4", {4'd0, amplitude}, 8'd7);
        hold = 1'b1;
        clocks(4);
        chk("attack_hold_s8", {4'd0, amplitude}, 8'd8);
        clocks(28);
        chk("attack_hold_s36", {4'd0, amplitude}, 8'd15);
        hold = 1'b0;
        // decay entered at s40, first decay tick at s48 collides with a strike
        clocks(11);
        chk("pre_tick_s47", {4'd0, amplitude}, 8'd15);
        strike_pulse();
        chk("tick_discard_s48", {4'd0, amplitude}, 8'd15);
        chk("tick_discard_busy", {7'd0, busy}, 8'd1);
        clocks(4);
        hold = 1'b1;
        // tone path: out follows tone_in two clocks later where pwm phase < 15
        for (int i = 0; i < 24; i++) begin
            tone_in = 1'($urandom_range(0, 1));
            p = pwm_m + 4'd1;
            push("tone_lat", {7'd0, tone_in & (p < 4'd15)});
            clocks(1);
            if (sb.size() >= 2) cmp({7'd0, out});
        end
        clocks(1);
        cmp({7'd0, out});
        chk("tone_amp_held", {4'd0, amplitude}, 8'd15);
        tone_in = 1'b1;
        hold = 1'b0;
        clocks(7);
        chk("decay_after_strike_r7", {4'd0, amplitude}, 8'd15);
        clocks(1);
        chk("decay_after_strike_r8", {4'd0, amplitude}, 8'd14);
        // hold at amplitude 4
        wait_amp(4'd4);
        hold = 1'b1;
        duty_count();
        chk("duty4_count", 8'(hi_cnt), 8'd4);
        chk("duty4_amp", {4'd0, amplitude}, 8'd4);
        hold = 1'b0;
        wait_amp(4'd0);
        chk("final_busy", {7'd0, busy}, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
